// File: rtl/per_bus_master.sv
// Host-to-peripheral bus bridge: turns one host request into a single registered peripheral
// access strobe and returns a formatted response with a fixed, parameterised read latency.
module per_bus_master #(
   parameter int unsigned RD_LAT = 0
) (
   input  logic        mclk,
   input  logic        puc,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [8:0]  req_addr,
   input  logic        req_wr,
   input  logic        req_byte,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [7:0]  per_addr,
   output logic [15:0] per_din,
   output logic        per_en,
   output logic [1:0]  per_wen,
   input  logic [15:0] per_dout
);

   typedef enum logic [1:0] {StIdle, StAccess, StLat, StResp} state_e;

   // Value of the LAT counter in the cycle where per_dout is sampled.
   localparam logic [1:0] LatLast = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

   state_e      state_q, state_d;
   logic        odd_q, odd_d;
   logic        wr_q, wr_d;
   logic        byte_q, byte_d;
   logic        err_q, err_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        per_en_q, per_en_d;
   logic [1:0]  per_wen_q, per_wen_d;
   logic [7:0]  per_addr_q, per_addr_d;
   logic [15:0] per_din_q, per_din_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        misaligned;

   function automatic logic [15:0] fmt_rdata(input logic [15:0] s, input logic b,
                                             input logic odd);
      if (!b) begin
         return s;
      end else if (odd) begin
         return {8'h00, s[15:8]};
      end
      return {8'h00, s[7:0]};
   endfunction

   assign misaligned = !req_byte && req_addr[0];
   assign req_ready  = (state_q == StIdle) && !puc;

   always_comb begin
      state_d     = state_q;
      odd_d       = odd_q;
      wr_d        = wr_q;
      byte_d      = byte_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      per_en_d    = 1'b0;
      per_wen_d   = 2'b00;
      per_addr_d  = 8'h00;
      per_din_d   = 16'h0000;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               state_d = StAccess;
               odd_d   = req_addr[0];
               wr_d    = req_wr;
               byte_d  = req_byte;
               err_d   = misaligned;
               // A misaligned word access still passes through ACCESS but never strobes.
               if (!misaligned) begin
                  per_en_d   = 1'b1;
                  per_addr_d = req_addr[8:1];
                  if (req_wr) begin
                     if (!req_byte) begin
                        per_wen_d = 2'b11;
                        per_din_d = req_wdata;
                     end else begin
                        per_wen_d = req_addr[0] ? 2'b10 : 2'b01;
                        per_din_d = {req_wdata[7:0], req_wdata[7:0]};
                     end
                  end
               end
            end
         end
         StAccess: begin
            if (err_q || wr_q) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               rsp_rdata_d = 16'h0000;
            end else if (RD_LAT == 0) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = fmt_rdata(per_dout, byte_q, odd_q);
            end else begin
               state_d = StLat;
               cnt_d   = 2'd0;
            end
         end
         StLat: begin
            if (cnt_q == LatLast) begin
               state_d     = StResp;
               cnt_d       = 2'd0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = fmt_rdata(per_dout, byte_q, odd_q);
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 16'h0000;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge mclk or posedge puc) begin
      if (puc) begin
         state_q     <= StIdle;
         odd_q       <= 1'b0;
         wr_q        <= 1'b0;
         byte_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= 2'd0;
         per_en_q    <= 1'b0;
         per_wen_q   <= 2'b00;
         per_addr_q  <= 8'h00;
         per_din_q   <= 16'h0000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         odd_q       <= odd_d;
         wr_q        <= wr_d;
         byte_q      <= byte_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         per_en_q    <= per_en_d;
         per_wen_q   <= per_wen_d;
         per_addr_q  <= per_addr_d;
         per_din_q   <= per_din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign per_en    = per_en_q;
   assign per_wen   = per_wen_q;
   assign per_addr  = per_addr_q;
   assign per_din   = per_din_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
